// File: rtl/ws_tile_sequencer.sv
// Weight-stationary tile sequencer: walks one tile through weight fill, kernel load,
// activation fill, execute and OFIFO drain, emitting the registered 64-bit core inst bus.
module ws_tile_sequencer #(
    parameter int unsigned ROW         = 8,
    parameter int unsigned COL         = 8,
    parameter int unsigned L0_DEPTH    = 64,
    parameter int unsigned OFIFO_DEPTH = 64,
    parameter int unsigned TIMEOUT     = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [10:0] w_base,
    input  logic [10:0] x_base,
    input  logic [10:0] p_base,
    input  logic [10:0] n_act,
    input  logic        first_tile,
    input  logic        last_tile,
    input  logic        ofifo_valid,
    output logic [63:0] inst,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int unsigned MAXN = (L0_DEPTH < OFIFO_DEPTH) ? L0_DEPTH : OFIFO_DEPTH;
    localparam int unsigned WW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [10:0]   ROW_C   = 11'(ROW);
    localparam logic [10:0]   ROW_M1  = 11'(ROW - 1);
    localparam logic [10:0]   COL_M1  = 11'(COL - 1);
    localparam logic [10:0]   MAXN_C  = 11'(MAXN);
    localparam logic [WW-1:0] TO_LAST = WW'(TIMEOUT - 1);

    localparam logic [63:0] IDLE_INST = 64'h0000_0001_000C_0000;

    typedef enum logic [3:0] {
        S_IDLE, S_W_FILL, S_W_LOAD, S_W_SETTLE, S_X_FILL,
        S_EXEC, S_DR_WAIT, S_DR_RD, S_DR_WR, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [10:0]   cnt_q, cnt_d;
    logic [10:0]   j_q, j_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [10:0]   wb_q, wb_d, xb_q, xb_d, pb_q, pb_d, n_q, n_d;
    logic          first_q, first_d, last_q, last_d;
    logic [63:0]   inst_q, inst_d;
    logic          busy_q, busy_d, done_q, done_d, err_q, err_d;

    // Outputs are registered but derived from the next state, so inst lines up
    // with the state the sequencer occupies during that cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        j_d     = j_q;
        wait_d  = wait_q;
        wb_d    = wb_q;
        xb_d    = xb_q;
        pb_d    = pb_q;
        n_d     = n_q;
        first_d = first_q;
        last_d  = last_q;
        err_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (n_act == 11'd0 || n_act > MAXN_C) begin
                        err_d = 1'b1;
                    end else begin
                        wb_d    = w_base;
                        xb_d    = x_base;
                        pb_d    = p_base;
                        n_d     = n_act;
                        first_d = first_tile;
                        last_d  = last_tile;
                        cnt_d   = '0;
                        state_d = S_W_FILL;
                    end
                end
            end
            S_W_FILL: begin
                cnt_d = cnt_q + 11'd1;
                if (cnt_q == ROW_C) begin
                    cnt_d   = '0;
                    state_d = S_W_LOAD;
                end
            end
            S_W_LOAD: begin
                cnt_d = cnt_q + 11'd1;
                if (cnt_q == ROW_M1) begin
                    cnt_d   = '0;
                    state_d = S_W_SETTLE;
                end
            end
            S_W_SETTLE: begin
                cnt_d = cnt_q + 11'd1;
                if (cnt_q == COL_M1) begin
                    cnt_d   = '0;
                    state_d = S_X_FILL;
                end
            end
            S_X_FILL: begin
                cnt_d = cnt_q + 11'd1;
                if (cnt_q == n_q) begin
                    cnt_d   = '0;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                cnt_d = cnt_q + 11'd1;
                if (cnt_q == n_q - 11'd1) begin
                    cnt_d   = '0;
                    j_d     = '0;
                    wait_d  = '0;
                    state_d = ofifo_valid ? S_DR_RD : S_DR_WAIT;
                end
            end
            S_DR_WAIT: begin
                if (ofifo_valid) begin
                    wait_d  = '0;
                    state_d = S_DR_RD;
                end else if (wait_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_DR_RD: state_d = S_DR_WR;
            S_DR_WR: begin
                if (j_q == n_q - 11'd1) begin
                    state_d = S_DONE;
                end else begin
                    j_d     = j_q + 11'd1;
                    wait_d  = '0;
                    state_d = ofifo_valid ? S_DR_RD : S_DR_WAIT;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        inst_d = IDLE_INST;
        unique case (state_d)
            S_W_FILL: begin
                if (cnt_d < ROW_C) begin
                    inst_d[19]   = 1'b0;
                    inst_d[17:7] = wb_d + cnt_d;
                end
                inst_d[2] = (cnt_d != 11'd0);
            end
            S_W_LOAD: begin
                inst_d[3] = 1'b1;
                inst_d[0] = 1'b1;
            end
            S_X_FILL: begin
                if (cnt_d < n_d) begin
                    inst_d[19]   = 1'b0;
                    inst_d[17:7] = xb_d + cnt_d;
                end
                inst_d[2] = (cnt_d != 11'd0);
            end
            S_EXEC: begin
                inst_d[3] = 1'b1;
                inst_d[1] = 1'b1;
            end
            S_DR_RD: begin
                inst_d[32]    = 1'b0;
                inst_d[35]    = 1'b1;
                inst_d[30:20] = pb_d + j_d;
            end
            S_DR_WR: begin
                inst_d[32]    = 1'b0;
                inst_d[31]    = 1'b1;
                inst_d[30:20] = pb_d + j_d;
                inst_d[6]     = 1'b1;
                inst_d[33]    = ~first_d;
                inst_d[34]    = first_d;
                inst_d[45]    = last_d;
            end
            default: ;
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            j_q     <= '0;
            wait_q  <= '0;
            wb_q    <= '0;
            xb_q    <= '0;
            pb_q    <= '0;
            n_q     <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            inst_q  <= IDLE_INST;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            j_q     <= j_d;
            wait_q  <= wait_d;
            wb_q    <= wb_d;
            xb_q    <= xb_d;
            pb_q    <= pb_d;
            n_q     <= n_d;
            first_q <= first_d;
            last_q  <= last_d;
            inst_q  <= inst_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign inst = inst_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_ws_tile_sequencer.sv
// Directed bench for ws_tile_sequencer: tile timing, address sequences, drain flags,
// backpressure, error paths, reset abort and address wrap.
module tb_ws_tile_sequencer;

    localparam logic [63:0] IDLE_INST = 64'h0000_0001_000C_0000;

    logic        clk = 1'b0;
    logic        reset, start, first_tile, last_tile, ofifo_valid;
    logic [10:0] w_base, x_base, p_base, n_act;
    logic [63:0] inst;
    logic        busy, done, err;

    int checks = 0;
    int failures = 0;

    int done_cyc, err_cnt, done_cnt, l0w_cnt, wr_ok, rd_cnt, wr101_cyc, rd102_cyc;
    logic [10:0] xa_q[$];
    logic [10:0] pw_q[$];

    ws_tile_sequencer #(
        .ROW(8), .COL(8), .L0_DEPTH(64), .OFIFO_DEPTH(64), .TIMEOUT(1024)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .w_base(w_base), .x_base(x_base), .p_base(p_base), .n_act(n_act),
        .first_tile(first_tile), .last_tile(last_tile), .ofifo_valid(ofifo_valid),
        .inst(inst), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode: 0 plain, 1 backpressure before output 2, 2 start pulsed in EXEC, 3 ofifo_valid stuck low
    task automatic run_tile(input logic [10:0] n, input logic [10:0] wb, input logic [10:0] xb,
                            input logic [10:0] pb, input logic first, input logic last,
                            input int mode, input int limit);
        int bp_left = 0;
        int fin = 0;
        bit pulsed = 1'b0;
        logic [10:0] a1, a2;
        a1 = pb + 11'd1;
        a2 = pb + 11'd2;
        done_cyc = 0; err_cnt = 0; done_cnt = 0; l0w_cnt = 0; wr_ok = 0; rd_cnt = 0;
        wr101_cyc = 0; rd102_cyc = 0;
        xa_q.delete();
        pw_q.delete();
        n_act = n; w_base = wb; x_base = xb; p_base = pb;
        first_tile = first; last_tile = last;
        ofifo_valid = (mode != 3);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc <= limit; cyc++) begin
            if (cyc > 1) begin
                tick();
                start = 1'b0;
                if (bp_left > 0) begin
                    bp_left--;
                    if (bp_left == 0) ofifo_valid = 1'b1;
                end
            end
            if (!inst[19]) xa_q.push_back(inst[17:7]);
            if (inst[2]) l0w_cnt++;
            if (inst[35]) begin
                rd_cnt++;
                if (mode == 1 && inst[30:20] == a2) rd102_cyc = cyc;
            end
            if (inst[31]) begin
                pw_q.push_back(inst[30:20]);
                if (inst[33] == !first && inst[34] == first && inst[45] == last && inst[6] && !inst[32])
                    wr_ok++;
                if (mode == 1 && inst[30:20] == a1) begin
                    wr101_cyc = cyc;
                    ofifo_valid = 1'b0;
                    bp_left = 5;
                end
            end
            if (mode == 2 && inst[1] && !pulsed) begin
                start = 1'b1;
                pulsed = 1'b1;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = cyc;
                if (fin == 0) fin = cyc;
            end
            if (err) begin
                err_cnt++;
                if (fin == 0) fin = cyc;
            end
            if (fin != 0 && cyc >= fin + 4) break;
        end
        start = 1'b0;
        ofifo_valid = 1'b1;
    endtask

    task automatic check_streams(input string tag, input logic [10:0] n, input logic [10:0] wb,
                                 input logic [10:0] xb, input logic [10:0] pb);
        logic [10:0] e;
        chk({tag, "_xa_len"}, 64'(xa_q.size()), 64'(8 + int'(n)));
        for (int i = 0; i < xa_q.size() && i < 8 + int'(n); i++) begin
            e = (i < 8) ? wb + 11'(i) : xb + 11'(i - 8);
            chk({tag, "_xa"}, 64'(xa_q[i]), 64'(e));
        end
        chk({tag, "_l0wr"}, 64'(l0w_cnt), 64'(8 + int'(n)));
        chk({tag, "_rd_cnt"}, 64'(rd_cnt), 64'(n));
        chk({tag, "_pw_len"}, 64'(pw_q.size()), 64'(n));
        for (int i = 0; i < pw_q.size() && i < int'(n); i++) begin
            e = pb + 11'(i);
            chk({tag, "_pw"}, 64'(pw_q[i]), 64'(e));
        end
        chk({tag, "_wr_flags"}, 64'(wr_ok), 64'(n));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; ofifo_valid = 1'b1;
        w_base = '0; x_base = '0; p_base = '0; n_act = '0;
        first_tile = 1'b1; last_tile = 1'b0;
        tick();
        tick();
        chk("rst_inst", inst, IDLE_INST);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        reset = 1'b0;
        tick();

        // T2 basic passthrough tile
        run_tile(11'd4, 11'd0, 11'd16, 11'd100, 1'b1, 1'b0, 0, 200);
        chk("t2_done_cyc", 64'(done_cyc), 64'd43);
        chk("t2_done_cnt", 64'(done_cnt), 64'd1);
        chk("t2_busy_after", 64'(busy), 64'd0);
        check_streams("t2", 11'd4, 11'd0, 11'd16, 11'd100);

        // T3 accumulate with ReLU
        run_tile(11'd4, 11'd0, 11'd16, 11'd100, 1'b0, 1'b1, 0, 200);
        chk("t3_done_cyc", 64'(done_cyc), 64'd43);
        check_streams("t3", 11'd4, 11'd0, 11'd16, 11'd100);

        // T4 backpressure before output 2
        run_tile(11'd4, 11'd0, 11'd16, 11'd100, 1'b1, 1'b0, 1, 200);
        chk("t4_done_cyc", 64'(done_cyc), 64'd48);
        chk("t4_rd102_gap", 64'(rd102_cyc - wr101_cyc), 64'd6);
        check_streams("t4", 11'd4, 11'd0, 11'd16, 11'd100);

        // T5 errors
        n_act = 11'd0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("t5_n0_err", 64'(err), 64'd1);
        chk("t5_n0_busy", 64'(busy), 64'd0);
        tick();
        chk("t5_n0_err_pulse", 64'(err), 64'd0);
        chk("t5_n0_busy2", 64'(busy), 64'd0);
        n_act = 11'd65; start = 1'b1;
        tick();
        start = 1'b0;
        chk("t5_n65_err", 64'(err), 64'd1);
        chk("t5_n65_busy", 64'(busy), 64'd0);
        tick();
        n_act = 11'd64; start = 1'b1;
        tick();
        start = 1'b0;
        chk("t5_n64_busy", 64'(busy), 64'd1);
        chk("t5_n64_err", 64'(err), 64'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        run_tile(11'd4, 11'd0, 11'd16, 11'd100, 1'b1, 1'b0, 3, 1300);
        chk("t5_to_err", 64'(err_cnt), 64'd1);
        chk("t5_to_done", 64'(done_cnt), 64'd0);
        chk("t5_to_busy", 64'(busy), 64'd0);
        chk("t5_to_writes", 64'(pw_q.size()), 64'd0);

        // T6 pmem address wrap, start ignored during EXEC
        run_tile(11'd4, 11'd2044, 11'd2046, 11'd2046, 1'b1, 1'b0, 2, 200);
        chk("t6_done_cnt", 64'(done_cnt), 64'd1);
        chk("t6_done_cyc", 64'(done_cyc), 64'd43);
        check_streams("t6", 11'd4, 11'd2044, 11'd2046, 11'd2046);
        chk("t6_busy_after", 64'(busy), 64'd0);

        // T1 reset during EXEC
        n_act = 11'd4; w_base = '0; x_base = 11'd16; p_base = 11'd100;
        ofifo_valid = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 100 && !inst[1]; k++) tick();
        chk("t1_in_exec", 64'(inst[1]), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t1_inst", inst, IDLE_INST);
        chk("t1_busy", 64'(busy), 64'd0);
        chk("t1_done", 64'(done), 64'd0);
        done_cnt = 0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (done || busy) done_cnt++;
        end
        chk("t1_stays_idle", 64'(done_cnt), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
